// File: rtl/steer_qual_if.sv
// Load-cell and steering-qualifier signal bundle between the balance-board front end and steer_qual.
// The master drives the load cells; the slave (steer_qual) returns the difference and qualifier flags.
interface steer_qual_if #(
  parameter int LD_W = 12
);
  logic        [LD_W-1:0] lft_ld;
  logic        [LD_W-1:0] rght_ld;
  logic signed [LD_W:0]   ld_cell_diff;
  logic                   en_steer;
  logic                   rider_off;

  modport master (
    output lft_ld,
    output rght_ld,
    input  ld_cell_diff,
    input  en_steer,
    input  rider_off
  );

  modport slave (
    input  lft_ld,
    input  rght_ld,
    output ld_cell_diff,
    output en_steer,
    output rider_off
  );
endinterface

// File: rtl/steer_qual.sv
// Rider qualification for steering: enables steering once a rider has stood balanced for the settle time.
// Define STEER_QUAL_FAST_SIM_EN to shrink the settle terminal count to TMR_FULL>>11 for simulation.
module steer_qual #(
  parameter int              LD_W         = 12,
  parameter logic [LD_W-1:0] MIN_RIDER_WT = 12'h200,
  parameter logic [LD_W-1:0] HYST         = 12'h040,
  parameter logic [25:0]     TMR_FULL     = 26'd65_000_000,
  parameter int              EN_SHIFT     = 2,
  parameter int              OFF_SHIFT    = 4
) (
  input logic         clk,
  input logic         rst,
  steer_qual_if.slave bus
);

`ifdef STEER_QUAL_FAST_SIM_EN
  localparam logic [25:0] TC = TMR_FULL >> 11;
`else
  localparam logic [25:0] TC = TMR_FULL;
`endif

  // A zero terminal count would give a zero-width timer, so keep at least one bit.
  localparam int               TMR_W   = (TC == 26'd0) ? 1 : $clog2(int'(TC) + 1);
  localparam logic [TMR_W-1:0] TC_CNT  = TMR_W'(TC);
  localparam logic [LD_W-1:0]  OFF_THR = MIN_RIDER_WT - HYST;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } state_t;

  logic        [LD_W:0]    sum;
  logic        [LD_W-1:0]  abs_diff;
  logic        [LD_W:0]    en_frac;
  logic        [LD_W:0]    off_frac;
  logic                    sum_gt_min;
  logic                    sum_lt_min;
  logic                    diff_gt_en;
  logic                    diff_gt_off;
  logic                    tmr_full;

  state_t                  state_q,     state_d;
  logic        [TMR_W-1:0] tmr_q,       tmr_d;
  logic                    en_steer_q,  en_steer_d;
  logic                    rider_off_q, rider_off_d;
  logic signed [LD_W:0]    diff_q,      diff_d;

  // Weight and balance qualifiers, all taken straight from the current samples.
  always_comb begin
    sum      = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    abs_diff = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                           : (bus.rght_ld - bus.lft_ld);
    en_frac  = sum >> EN_SHIFT;
    off_frac = sum - (sum >> OFF_SHIFT);

    sum_gt_min  = sum > {1'b0, MIN_RIDER_WT};
    sum_lt_min  = sum < {1'b0, OFF_THR};
    diff_gt_en  = {1'b0, abs_diff} > en_frac;
    diff_gt_off = {1'b0, abs_diff} > off_frac;
    tmr_full    = (tmr_q == TC_CNT);
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
    state_d     = state_q;
    tmr_d       = tmr_q;
    rider_off_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sum_gt_min) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end

      WAIT: begin
        if (sum_lt_min) begin
          state_d     = IDLE;
          rider_off_d = 1'b1;
        end else if (diff_gt_en) begin
          tmr_d = '0;
        end else begin
          // Settle timer saturates at the terminal count rather than wrapping.
          if (!tmr_full) tmr_d = tmr_q + TMR_W'(1);
          if (tmr_full)  state_d = STEER_EN;
        end
      end

      STEER_EN: begin
        if (sum_lt_min) begin
          state_d     = IDLE;
          rider_off_d = 1'b1;
        end else if (diff_gt_off) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    en_steer_d = (state_d == STEER_EN);
    diff_d     = $signed({1'b0, bus.lft_ld}) - $signed({1'b0, bus.rght_ld});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b0;
      diff_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
      diff_q      <= diff_d;
    end
  end

  assign bus.en_steer     = en_steer_q;
  assign bus.rider_off    = rider_off_q;
  assign bus.ld_cell_diff = diff_q;

endmodule

// File: tb/tb_steer_qual.sv
// Bench for steer_qual: directed vector table, reset sequences, then randomized segments
// compared cycle by cycle against a behavioural model of the rider-qualification rules.
module tb_steer_qual;
  localparam int LD_W = 12;
`ifdef STEER_QUAL_FAST_SIM_EN
  localparam logic [25:0] TMR_FULL = 26'd65_000_000;
  localparam int          TC       = 65_000_000 >> 11;
`else
  localparam logic [25:0] TMR_FULL = 26'd100;
  localparam int          TC       = 100;
`endif
  localparam int MIN_WT  = 'h200;
  localparam int OFF_THR = 'h200 - 'h040;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  steer_qual_if #(.LD_W(LD_W)) bus ();

  steer_qual #(
    .LD_W    (LD_W),
    .TMR_FULL(TMR_FULL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = no rider, 1 = settling, 2 = steering enabled.
  int m_mode, m_settled, m_en, m_off, m_diff;

  function automatic void model_reset();
    m_mode = 0; m_settled = 0; m_en = 0; m_off = 0; m_diff = 0;
  endfunction

  function automatic void model_edge(input int l, input int r);
    int s, ad, prev;
    s    = l + r;
    ad   = (l > r) ? l - r : r - l;
    prev = m_mode;
    case (m_mode)
      0: if (s > MIN_WT) begin m_mode = 1; m_settled = 0; end
      1: begin
        if (s < OFF_THR)      m_mode = 0;
        else if (ad > s / 4)  m_settled = 0;
        else if (m_settled >= TC) m_mode = 2;
        else                  m_settled = m_settled + 1;
      end
      default: begin
        if (s < OFF_THR)               m_mode = 0;
        else if (ad > s - s / 16) begin m_mode = 1; m_settled = 0; end
      end
    endcase
    m_off  = (m_mode == 0 && prev != 0) ? 1 : 0;
    m_en   = (m_mode == 2) ? 1 : 0;
    m_diff = l - r;
  endfunction

  // Drive one cycle (called #1 after a rising edge), then compare against the model.
  task automatic run_cycle(input int l, input int r, input string tag);
    bus.lft_ld  = LD_W'(l);
    bus.rght_ld = LD_W'(r);
    model_edge(l, r);
    @(posedge clk);
    #1;
    check({tag, ".en_steer"},  int'(bus.en_steer),     m_en);
    check({tag, ".rider_off"}, int'(bus.rider_off),    m_off);
    check({tag, ".diff"},      int'(bus.ld_cell_diff), m_diff);
  endtask

  task automatic hold(input int l, input int r, input int n, input string tag);
    for (int i = 0; i < n; i++) run_cycle(l, r, tag);
  endtask

  task automatic check_outs(input string tag, input int en, input int off, input int diff);
    check({tag, ".en_steer"},  int'(bus.en_steer),     en);
    check({tag, ".rider_off"}, int'(bus.rider_off),    off);
    check({tag, ".diff"},      int'(bus.ld_cell_diff), diff);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge, and no pulse appears.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1 check_outs({tag, ".async"}, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_outs({tag, ".held"}, 0, 0, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    string name;
    int    l;
    int    r;
    int    n;
    int    en;
    int    off;
    int    diff;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cat, l, r, n, base, s;

    rst         = 1'b1;
    bus.lft_ld  = '0;
    bus.rght_ld = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outs("reset", 0, 0, 0);
    rst = 1'b0;

    tbl.push_back('{"bal_enter_wait",  'h180, 'h180, 1,      0, 0, 0});
    tbl.push_back('{"bal_tc_minus",    'h180, 'h180, TC,     0, 0, 0});
    tbl.push_back('{"bal_en_rise",     'h180, 'h180, 1,      1, 0, 0});
    tbl.push_back('{"steer_off_diff",  'h2F0, 'h010, 1,      0, 0, 'h2E0});
    tbl.push_back('{"resettle_minus",  'h180, 'h180, TC,     0, 0, 0});
    tbl.push_back('{"resettle_rise",   'h180, 'h180, 1,      1, 0, 0});
    tbl.push_back('{"steer_1d0_stay",  'h0E8, 'h0E8, 1,      1, 0, 0});
    tbl.push_back('{"steer_1b0_off",   'h0D8, 'h0D8, 1,      0, 1, 0});
    tbl.push_back('{"idle_after_off",  'h0D8, 'h0D8, 1,      0, 0, 0});
    tbl.push_back('{"imbal_enter",     'h200, 'h100, 1,      0, 0, 'h100});
    tbl.push_back('{"imbal_hold300",   'h200, 'h100, 300,    0, 0, 'h100});
    tbl.push_back('{"imbal_bal_minus", 'h180, 'h180, TC,     0, 0, 0});
    tbl.push_back('{"imbal_bal_rise",  'h180, 'h180, 1,      1, 0, 0});
    tbl.push_back('{"band_low_steer",  'h0E0, 'h0E0, 3,      1, 0, 0});
    tbl.push_back('{"band_high_steer", 'h100, 'h100, 3,      1, 0, 0});
    tbl.push_back('{"below_band_off",  'h0E0, 'h0DF, 1,      0, 1, 1});
    tbl.push_back('{"idle_at_min",     'h100, 'h100, 5,      0, 0, 0});
    tbl.push_back('{"idle_above_min",  'h101, 'h100, 1,      0, 0, 1});
    tbl.push_back('{"wait_band_low",   'h0E0, 'h0E0, 4,      0, 0, 0});
    tbl.push_back('{"wait_below_off",  'h0E0, 'h0DF, 1,      0, 1, 1});
    tbl.push_back('{"neg_diff",        'h010, 'h2F0, 1,      0, 0, -'h2E0});

    foreach (tbl[k]) begin
      hold(tbl[k].l, tbl[k].r, tbl[k].n, tbl[k].name);
      check_outs({"tbl.", tbl[k].name}, tbl[k].en, tbl[k].off, tbl[k].diff);
    end

    // Reset at settle count 50, then a full settle from scratch.
    async_reset("rst_pre");
    hold('h190, 'h170, 51, "rst_wait50");
    check_outs("rst_wait50", 0, 0, 'h20);
    async_reset("rst_mid_wait");
    hold('h190, 'h170, 1,  "post_rst_enter");
    hold('h190, 'h170, TC, "post_rst_settle");
    check_outs("post_rst_minus", 0, 0, 'h20);
    hold('h190, 'h170, 1,  "post_rst_rise");
    check_outs("post_rst_rise", 1, 0, 'h20);
    hold('h190, 'h170, 2,  "steer_hold");
    async_reset("rst_mid_steer");

    for (int seg = 0; seg < 40; seg++) begin
      cat = $urandom_range(0, 4);
      case (cat)
        0: begin
          base = $urandom_range('h0E8, 'h700);
          l = base + $urandom_range(0, 16);
          r = base;
          n = $urandom_range(1, TC + 30);
        end
        1: begin
          l = $urandom_range(0, 'hFFF);
          r = $urandom_range(0, 'hFFF);
          n = $urandom_range(1, 20);
        end
        2: begin
          l = $urandom_range(0, 'hE0);
          r = $urandom_range(0, 'hE0);
          n = $urandom_range(1, 20);
        end
        3: begin
          s = $urandom_range(OFF_THR, MIN_WT);
          l = s / 2;
          r = s - l;
          n = $urandom_range(1, 20);
        end
        default: begin
          l = $urandom_range('h400, 'hFFF);
          r = $urandom_range(0, 'h20);
          n = $urandom_range(1, 20);
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        s = l; l = r; r = s;
      end
      hold(l, r, n, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
